// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction size and reset constants.
package mips_pkg;

    typedef enum logic [1:0] {
        S_RESET,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

endpackage

// File: rtl/fetch_ir_reg.sv
// One-entry instruction/PC holding register between fetch and decode.
// A flush drops the held entry and suppresses any load in the same cycle.
module fetch_ir_reg
    import mips_pkg::*;
(
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_load,
    input  logic [31:0] w_load_ir_32,
    input  logic [31:0] w_load_pc_32,
    input  logic        w_flush,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [31:0] w_ir_32,
    output logic [31:0] w_dpc_32
);

    logic        valid_q, valid_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] dpc_q, dpc_d;

    // Next entry: flush wins, then a new load, then consumption by decode.
    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        dpc_d   = dpc_q;
        if (w_flush) begin
            valid_d = 1'b0;
        end else if (w_load) begin
            valid_d = 1'b1;
            ir_d    = w_load_ir_32;
            dpc_d   = w_load_pc_32;
        end else if (w_ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            valid_q <= 1'b0;
            ir_q    <= NOP_WORD;
            dpc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            dpc_q   <= dpc_d;
        end
    end

    assign w_valid  = valid_q;
    assign w_ir_32  = ir_q;
    assign w_dpc_32 = dpc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch-PC registers, imem req/ack handshake, redirect
// draining and a sticky request timeout flag. Holds one instruction for decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_redirect,
    input  logic [31:0] w_pc_advanced_in_32,
    input  logic [31:0] w_pc_in_32,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr_32,
    input  logic        w_imem_ack,
    input  logic [31:0] w_imem_rdata_32,
    output logic        w_ir_valid,
    input  logic        w_ir_ready,
    output logic [31:0] w_ir_32,
    output logic [31:0] w_dpc_out_32,
    output logic [31:0] w_pc_32,
    output logic        w_fetch_err
);

    localparam logic [31:0] STEP      = 32'(INSTR_BYTES);
    localparam logic [7:0]  TO_LIMIT  = 8'(TIMEOUT_CYC);
    localparam logic [31:0] ADDR_MASK = ~32'h3;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  next_pc_q, next_pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [7:0]   to_cnt_q, to_cnt_d;
    logic         err_q, err_d;

    logic         ir_valid;
    logic         slot_free;
    logic         req;
    logic         waiting;
    logic         ir_load;
    logic [31:0]  addr_raw;

    assign slot_free = !ir_valid || w_ir_ready;

    // Request is raised only when the IR slot can take the returning word; a
    // drain keeps the old request up regardless, so the memory sees a stable req.
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            S_REQ, S_HOLD: req = slot_free;
            S_DRAIN:       req = 1'b1;
            default:       req = 1'b0;
        endcase
    end

    assign waiting  = req && !w_imem_ack;
    assign ir_load  = req && w_imem_ack && (state_q != S_DRAIN) && !w_redirect;
    // During a drain the PC already holds the redirect target, so the address
    // of the abandoned request is replayed from its own register.
    assign addr_raw = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;

    // Next state, PC sequencing and timeout tracking; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        next_pc_d    = next_pc_q;
        drain_addr_d = drain_addr_q;
        if (w_redirect) begin
            fetch_pc_d = w_pc_advanced_in_32;
            next_pc_d  = w_pc_in_32;
            state_d    = waiting ? S_DRAIN : S_REQ;
            if (waiting && (state_q != S_DRAIN)) begin
                drain_addr_d = fetch_pc_q;
            end
        end else begin
            unique case (state_q)
                S_RESET: state_d = S_REQ;
                S_REQ, S_HOLD: begin
                    if (ir_load) begin
                        fetch_pc_d = next_pc_q;
                        next_pc_d  = next_pc_q + STEP;
                        state_d    = S_REQ;
                    end else begin
                        state_d = slot_free ? S_REQ : S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (w_imem_ack) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_RESET;
            endcase
        end

        to_cnt_d = to_cnt_q;
        if (w_imem_ack) begin
            to_cnt_d = '0;
        end else if (waiting && (to_cnt_q != '1)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
        err_d = err_q || (waiting && ((to_cnt_q + 8'd1) == TO_LIMIT));
    end

    // Fetch state, PC and timeout registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q      <= S_RESET;
            fetch_pc_q   <= RESET_VEC;
            next_pc_q    <= RESET_VEC + STEP;
            drain_addr_q <= '0;
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            next_pc_q    <= next_pc_d;
            drain_addr_q <= drain_addr_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
        end
    end

    fetch_ir_reg u_ir_reg (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_load       (ir_load),
        .w_load_ir_32 (w_imem_rdata_32),
        .w_load_pc_32 (fetch_pc_q & ADDR_MASK),
        .w_flush      (w_redirect),
        .w_ready      (w_ir_ready),
        .w_valid      (ir_valid),
        .w_ir_32      (w_ir_32),
        .w_dpc_32     (w_dpc_out_32)
    );

    assign w_imem_req     = req;
    assign w_imem_addr_32 = addr_raw & ADDR_MASK;
    assign w_ir_valid     = ir_valid;
    assign w_pc_32        = fetch_pc_q;
    assign w_fetch_err    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory (word = ~address)
// and a scoreboard of expected fetch addresses consumed by decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] adv_in = '0;
    logic [31:0] pc_in = '0;
    logic        ack = 1'b0;
    logic        ready = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] dpc;
    logic [31:0] pc;
    logic        err;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign rdata = ~addr;

    fetch_unit #(
        .RESET_VEC   (32'h0000_0000),
        .TIMEOUT_CYC (4)
    ) dut (
        .w_clk               (clk),
        .w_rst_n             (rst_n),
        .w_redirect          (redirect),
        .w_pc_advanced_in_32 (adv_in),
        .w_pc_in_32          (pc_in),
        .w_imem_req          (req),
        .w_imem_addr_32      (addr),
        .w_imem_ack          (ack),
        .w_imem_rdata_32     (rdata),
        .w_ir_valid          (valid),
        .w_ir_ready          (ready),
        .w_ir_32             (ir),
        .w_dpc_out_32        (dpc),
        .w_pc_32             (pc),
        .w_fetch_err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, then retire a scoreboard entry if decode takes the IR.
    task automatic settle();
        logic [31:0] e;
        #1;
        if (valid && ready && !redirect) begin
            n_chk++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected observed_ir=%h expected=none", ir);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_ir", ir, ~e);
                chk("sb_dpc", dpc, e);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_dpc", dpc, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pc", pc, 32'h0);

        // 1: zero-wait streaming
        adv(); rst_n = 1'b1; ack = 1'b1; settle();
        chk("t1_reset_cycle_req", 32'(req), 32'd0);
        adv(); exp_q.push_back(32'h0); settle();
        chk("t1_req0", 32'(req), 32'd1);
        chk("t1_addr0", addr, 32'h0);
        adv(); exp_q.push_back(32'h4); settle();
        chk("t1_addr4", addr, 32'h4);
        adv(); exp_q.push_back(32'h8); settle();
        chk("t1_addr8", addr, 32'h8);

        // 2: ack withheld 3 cycles on 0xC
        adv(); ack = 1'b0; settle();
        chk("t2_req", 32'(req), 32'd1);
        chk("t2_addr_w1", addr, 32'hC);
        adv(); settle();
        chk("t2_addr_w2", addr, 32'hC);
        chk("t2_valid_w2", 32'(valid), 32'd0);
        adv(); settle();
        chk("t2_addr_w3", addr, 32'hC);
        chk("t2_valid_w3", 32'(valid), 32'd0);
        adv(); ack = 1'b1; exp_q.push_back(32'hC); settle();
        chk("t2_addr_ack", addr, 32'hC);
        chk("t2_req_ack", 32'(req), 32'd1);

        // 3: decode stalls 5 cycles
        adv(); ack = 1'b0; ready = 1'b0; settle();
        chk("t3_valid", 32'(valid), 32'd1);
        chk("t3_req", 32'(req), 32'd0);
        chk("t3_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            adv(); settle();
            chk("t3_hold_req", 32'(req), 32'd0);
            chk("t3_hold_ir", ir, ~32'hC);
            chk("t3_hold_dpc", dpc, 32'hC);
            chk("t3_hold_pc", pc, 32'h10);
        end
        adv(); ready = 1'b1; ack = 1'b1; exp_q.push_back(32'h10); settle();
        chk("t3_refetch_req", 32'(req), 32'd1);
        chk("t3_refetch_addr", addr, 32'h10);

        // 4: redirect while 0x14 is outstanding
        adv(); ack = 1'b0; settle();
        chk("t4_addr_pend", addr, 32'h14);
        adv(); redirect = 1'b1; adv_in = 32'h100; pc_in = 32'h104; settle();
        chk("t4_addr_redir", addr, 32'h14);
        adv(); redirect = 1'b0; ack = 1'b1; settle();
        chk("t4_drain_req", 32'(req), 32'd1);
        chk("t4_drain_addr", addr, 32'h14);
        chk("t4_drain_pc", pc, 32'h100);
        chk("t4_drain_valid", 32'(valid), 32'd0);
        adv(); exp_q.push_back(32'h100); settle();
        chk("t4_addr_tgt", addr, 32'h100);
        chk("t4_valid_dropped", 32'(valid), 32'd0);
        adv(); settle();
        chk("t4_addr_next", addr, 32'h104);

        // 5: redirect coincident with ack and ready
        adv(); redirect = 1'b1; adv_in = 32'h200; pc_in = 32'h204; settle();
        chk("t5_valid_before", 32'(valid), 32'd1);
        chk("t5_ir_before", ir, ~32'h104);
        chk("t5_addr", addr, 32'h108);
        adv(); redirect = 1'b0; exp_q.push_back(32'h200); settle();
        chk("t5_squashed", 32'(valid), 32'd0);
        chk("t5_no_drain_addr", addr, 32'h200);
        chk("t5_req", 32'(req), 32'd1);

        // 6: timeout and asynchronous reset mid-request
        adv(); ack = 1'b0; settle();
        chk("t6_addr", addr, 32'h204);
        adv(); settle();
        chk("t6_err_w2", 32'(err), 32'd0);
        adv(); settle();
        chk("t6_err_w3", 32'(err), 32'd0);
        adv(); settle();
        chk("t6_err_w4", 32'(err), 32'd0);
        adv(); settle();
        chk("t6_err_set", 32'(err), 32'd1);
        chk("t6_req_held", 32'(req), 32'd1);
        chk("t6_addr_held", addr, 32'h204);
        adv(); settle();
        chk("t6_err_sticky", 32'(err), 32'd1);
        #1; rst_n = 1'b0; #1;
        chk("t6_arst_req", 32'(req), 32'd0);
        chk("t6_arst_valid", 32'(valid), 32'd0);
        chk("t6_arst_ir", ir, 32'h0);
        chk("t6_arst_dpc", dpc, 32'h0);
        chk("t6_arst_err", 32'(err), 32'd0);
        chk("t6_arst_pc", pc, 32'h0);
        adv(); rst_n = 1'b1; ack = 1'b1; settle();
        chk("t6_rel_req", 32'(req), 32'd0);
        adv(); settle();
        chk("t6_refetch_req", 32'(req), 32'd1);
        chk("t6_refetch_addr", addr, 32'h0);

        // address masking and PC wrap
        adv(); redirect = 1'b1; adv_in = 32'hFFFF_FFF9; pc_in = 32'hFFFF_FFFC; settle();
        chk("w_ir0", ir, ~32'h0);
        chk("w_dpc0", dpc, 32'h0);
        chk("w_addr4", addr, 32'h4);
        adv(); redirect = 1'b0; exp_q.push_back(32'hFFFF_FFF8); settle();
        chk("w_addr_mask", addr, 32'hFFFF_FFF8);
        chk("w_pc_raw", pc, 32'hFFFF_FFF9);
        adv(); exp_q.push_back(32'hFFFF_FFFC); settle();
        chk("w_addr_fc", addr, 32'hFFFF_FFFC);
        adv(); exp_q.push_back(32'h0); settle();
        chk("w_addr_wrap", addr, 32'h0);
        adv(); ack = 1'b0; settle();
        chk("w_addr_after", addr, 32'h4);
        adv(); settle();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
